// File: rtl/gpio_pixel_packer.sv
// Captures per-channel GPIO byte writes into three byte FIFOs and re-assembles
// them into {R,G,B} pixels behind a valid/ready output register.
module gpio_pixel_packer #(
    parameter int DEPTH = 16,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] GPIO,
    input  logic        GPIOEnR,
    input  logic        GPIOEnG,
    input  logic        GPIOEnB,
    input  logic        vf,
    output logic        pix_valid,
    input  logic        pix_ready,
    output logic [23:0] pix_data,
    output logic [31:0] pix_count,
    output logic        overflow,
    output logic        en_err
);

    localparam int NCH = 3;
    localparam logic [PTR_W+1:0] DEPTH_L = DEPTH[PTR_W+1:0];

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [PTR_W:0]   occ_t;

    logic [7:0] mem [NCH][DEPTH];
    ptr_t       wr_ptr [NCH];
    ptr_t       rd_ptr [NCH];
    occ_t       occ    [NCH];

    logic [NCH-1:0] en_sel;
    logic [NCH-1:0] push;
    logic [2:0]     push_n;
    occ_t           occ_sel;
    logic [PTR_W+1:0] occ_sum;
    logic           space_ok;
    logic           any_en;
    logic           multi_en;
    logic           reject;
    logic           load;
    logic [23:0]    head;

    always_comb begin
        // NOTE: every signal driven here gets a default first, so no branch can leave a latch behind.
        en_sel  = '0;
        occ_sel = occ[0];
        if (GPIOEnR) begin
            en_sel  = 3'b001;
            occ_sel = occ[0];
        end else if (GPIOEnG) begin
            en_sel  = 3'b010;
            occ_sel = occ[1];
        end else if (GPIOEnB) begin
            en_sel  = 3'b100;
            occ_sel = occ[2];
        end
        any_en   = GPIOEnR | GPIOEnG | GPIOEnB;
        multi_en = (GPIOEnR & GPIOEnG) | (GPIOEnR & GPIOEnB) | (GPIOEnG & GPIOEnB);
        push_n   = vf ? 3'd4 : 3'd1;
        // Space is judged on pre-cycle occupancy only; a same-cycle pop earns no credit.
        occ_sum  = {1'b0, occ_sel} + {{(PTR_W-1){1'b0}}, push_n};
        space_ok = occ_sum <= DEPTH_L;
        push     = space_ok ? en_sel : '0;
        reject   = any_en & ~space_ok;
        load     = (occ[0] != '0) && (occ[1] != '0) && (occ[2] != '0)
                   && (!pix_valid || pix_ready);
        head     = {mem[0][rd_ptr[0]], mem[1][rd_ptr[1]], mem[2][rd_ptr[2]]};
    end

    // NOTE: state registers use <= so each one samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NCH; c++) begin
                wr_ptr[c] <= '0;
                rd_ptr[c] <= '0;
                occ[c]    <= '0;
            end
        end else begin
            for (int c = 0; c < NCH; c++) begin
                if (push[c])
                    wr_ptr[c] <= wr_ptr[c] + ptr_t'(push_n);
                if (load)
                    rd_ptr[c] <= rd_ptr[c] + ptr_t'(1);
                occ[c] <= occ[c] + (push[c] ? occ_t'(push_n) : occ_t'(0)) - occ_t'(load);
            end
        end
    end

    // NOTE: byte storage is deliberately not reset; pointers and occupancies alone define what is valid.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NCH; c++) begin
            if (push[c]) begin
                for (int k = 0; k < 4; k++) begin
                    if (vf || k == 0)
                        mem[c][wr_ptr[c] + ptr_t'(k)] <= GPIO[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pix_valid <= 1'b0;
            pix_data  <= '0;
            pix_count <= '0;
            overflow  <= 1'b0;
            en_err    <= 1'b0;
        end else begin
            if (load) begin
                pix_valid <= 1'b1;
                pix_data  <= head;
            end else if (pix_valid && pix_ready) begin
                pix_valid <= 1'b0;
            end
            if (pix_valid && pix_ready)
                pix_count <= pix_count + 32'd1;
            if (reject)
                overflow <= 1'b1;
            if (multi_en)
                en_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_gpio_pixel_packer.sv
// Directed bench for gpio_pixel_packer: a cycle table for the basic pixel paths
// plus hand sequences for overflow, reset mid-transfer and pointer wrap.
module tb_gpio_pixel_packer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] GPIO = '0;
    logic        GPIOEnR = 1'b0;
    logic        GPIOEnG = 1'b0;
    logic        GPIOEnB = 1'b0;
    logic        vf = 1'b0;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic [23:0] pix_data;
    logic [31:0] pix_count;
    logic        overflow;
    logic        en_err;

    gpio_pixel_packer #(.DEPTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .GPIO      (GPIO),
        .GPIOEnR   (GPIOEnR),
        .GPIOEnG   (GPIOEnG),
        .GPIOEnB   (GPIOEnB),
        .vf        (vf),
        .pix_valid (pix_valid),
        .pix_ready (pix_ready),
        .pix_data  (pix_data),
        .pix_count (pix_count),
        .overflow  (overflow),
        .en_err    (en_err)
    );

    initial forever #5 clk = ~clk;

    int vec_cnt  = 0;
    int miss_cnt = 0;
    logic [23:0] exp_q [$];
    bit mon_on = 1'b0;

    typedef struct {
        logic [2:0]  en;    // {B,G,R}
        logic        v;
        logic [31:0] d;
        logic        rdy;
        logic        ev;
        logic [23:0] ed;
        logic [31:0] ec;
        logic        eo;
        logic        ee;
    } vec_t;

    vec_t tbl [$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miss_cnt++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [2:0] en, input logic v, input logic [31:0] d);
        {GPIOEnB, GPIOEnG, GPIOEnR} = en;
        vf   = v;
        GPIO = d;
        step();
        {GPIOEnB, GPIOEnG, GPIOEnR} = 3'b000;
        vf   = 1'b0;
        GPIO = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic wait_drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 300) begin
            step();
            n++;
        end
        if (exp_q.size() != 0) begin
            vec_cnt++;
            miss_cnt++;
            $display("FAIL %s drain: %0d pixels outstanding, required 0", name, exp_q.size());
            exp_q.delete();
        end
        step();
        step();
        check({name, " idle after drain"}, 32'(pix_valid), 32'd0);
    endtask

    function automatic logic [31:0] pack4(input logic [7:0] b);
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    function automatic void add(input logic [2:0] en, input logic v, input logic [31:0] d,
                                input logic rdy, input logic ev, input logic [23:0] ed,
                                input logic [31:0] ec, input logic eo, input logic ee);
        tbl.push_back('{en, v, d, rdy, ev, ed, ec, eo, ee});
    endfunction

    // Every completed handshake is matched against the expected pixel queue.
    always @(negedge clk) begin
        if (mon_on && !rst && pix_valid && pix_ready) begin
            if (exp_q.size() == 0) begin
                vec_cnt++;
                miss_cnt++;
                $display("FAIL pixel_stream: got %06h, required no pixel", pix_data);
            end else begin
                check("pixel_stream", {8'h0, pix_data}, {8'h0, exp_q.pop_front()});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        logic [31:0] rw, gw, bw;

        step();
        step();
        check("reset pix_valid", 32'(pix_valid), 32'd0);
        check("reset pix_data",  32'(pix_data),  32'd0);
        check("reset pix_count", pix_count,      32'd0);
        check("reset overflow",  32'(overflow),  32'd0);
        check("reset en_err",    32'(en_err),    32'd0);
        rst = 1'b0;

        // Scalar writes, one pixel.
        add(3'b001, 0, 32'h11, 1, 0, 24'h0, 0, 0, 0);
        add(3'b010, 0, 32'h22, 1, 0, 24'h0, 0, 0, 0);
        add(3'b100, 0, 32'h33, 1, 0, 24'h0, 0, 0, 0);
        add(3'b000, 0, 32'h0,  1, 1, 24'h112233, 0, 0, 0);
        add(3'b000, 0, 32'h0,  1, 0, 24'h0, 1, 0, 0);
        // Vector writes, four back-to-back pixels.
        add(3'b001, 1, 32'h44332211, 1, 0, 24'h0, 1, 0, 0);
        add(3'b010, 1, 32'h88776655, 1, 0, 24'h0, 1, 0, 0);
        add(3'b100, 1, 32'hCCBBAA99, 1, 0, 24'h0, 1, 0, 0);
        add(3'b000, 0, 32'h0, 1, 1, 24'h115599, 1, 0, 0);
        add(3'b000, 0, 32'h0, 1, 1, 24'h2266AA, 2, 0, 0);
        add(3'b000, 0, 32'h0, 1, 1, 24'h3377BB, 3, 0, 0);
        add(3'b000, 0, 32'h0, 1, 1, 24'h4488CC, 4, 0, 0);
        add(3'b000, 0, 32'h0, 1, 0, 24'h0, 5, 0, 0);
        // Same with a five-cycle stall on the first pixel.
        add(3'b001, 1, 32'h44332211, 1, 0, 24'h0, 5, 0, 0);
        add(3'b010, 1, 32'h88776655, 1, 0, 24'h0, 5, 0, 0);
        add(3'b100, 1, 32'hCCBBAA99, 1, 0, 24'h0, 5, 0, 0);
        for (int i = 0; i < 5; i++)
            add(3'b000, 0, 32'h0, 0, 1, 24'h115599, 5, 0, 0);
        add(3'b000, 0, 32'h0, 1, 1, 24'h2266AA, 6, 0, 0);
        add(3'b000, 0, 32'h0, 1, 1, 24'h3377BB, 7, 0, 0);
        add(3'b000, 0, 32'h0, 1, 1, 24'h4488CC, 8, 0, 0);
        add(3'b000, 0, 32'h0, 1, 0, 24'h0, 9, 0, 0);
        // Simultaneous enables: R wins over B, then G wins over B.
        add(3'b101, 0, 32'hAB, 1, 0, 24'h0, 9, 0, 1);
        add(3'b010, 0, 32'h01, 1, 0, 24'h0, 9, 0, 1);
        add(3'b100, 0, 32'h02, 1, 0, 24'h0, 9, 0, 1);
        add(3'b000, 0, 32'h0,  1, 1, 24'hAB0102, 9, 0, 1);
        add(3'b000, 0, 32'h0,  1, 0, 24'h0, 10, 0, 1);
        add(3'b110, 0, 32'hCD, 1, 0, 24'h0, 10, 0, 1);
        add(3'b001, 0, 32'hEF, 1, 0, 24'h0, 10, 0, 1);
        add(3'b100, 0, 32'h5A, 1, 0, 24'h0, 10, 0, 1);
        add(3'b000, 0, 32'h0,  1, 1, 24'hEFCD5A, 10, 0, 1);
        add(3'b000, 0, 32'h0,  1, 0, 24'h0, 11, 0, 1);

        foreach (tbl[i]) begin
            {GPIOEnB, GPIOEnG, GPIOEnR} = tbl[i].en;
            vf        = tbl[i].v;
            GPIO      = tbl[i].d;
            pix_ready = tbl[i].rdy;
            step();
            check($sformatf("row%0d pix_valid", i), 32'(pix_valid), 32'(tbl[i].ev));
            if (tbl[i].ev)
                check($sformatf("row%0d pix_data", i), 32'(pix_data), 32'(tbl[i].ed));
            check($sformatf("row%0d pix_count", i), pix_count, tbl[i].ec);
            check($sformatf("row%0d overflow", i), 32'(overflow), 32'(tbl[i].eo));
            check($sformatf("row%0d en_err", i), 32'(en_err), 32'(tbl[i].ee));
        end
        {GPIOEnB, GPIOEnG, GPIOEnR} = 3'b000;
        vf   = 1'b0;
        GPIO = '0;

        // Full R rejects a scalar write; then reset while a pixel is held.
        mon_on    = 1'b1;
        pix_ready = 1'b0;
        for (int j = 0; j < 4; j++)
            drive(3'b001, 1, pack4(8'(4 * j)));
        drive(3'b001, 0, 32'hEE);
        check("full R scalar overflow", 32'(overflow), 32'd1);
        check("full R no pixel", 32'(pix_valid), 32'd0);
        drive(3'b010, 1, pack4(8'h10));
        drive(3'b100, 1, pack4(8'h20));
        step();
        check("stall valid", 32'(pix_valid), 32'd1);
        check("stall data", 32'(pix_data), 32'h001020);
        step();
        check("stall hold data", 32'(pix_data), 32'h001020);
        check("stall hold count", pix_count, 32'd11);
        rst       = 1'b1;
        pix_ready = 1'b1;
        step();
        check("midreset pix_valid", 32'(pix_valid), 32'd0);
        check("midreset pix_data",  32'(pix_data),  32'd0);
        check("midreset pix_count", pix_count,      32'd0);
        check("midreset overflow",  32'(overflow),  32'd0);
        check("midreset en_err",    32'(en_err),    32'd0);
        rst = 1'b0;
        step();
        step();
        step();
        check("post-reset fifos empty", 32'(pix_valid), 32'd0);
        exp_q.push_back(24'h616263);
        drive(3'b001, 0, 32'h61);
        drive(3'b010, 0, 32'h62);
        drive(3'b100, 0, 32'h63);
        wait_drain("post-reset pixel");

        // Full R keeps exactly 16 bytes after a rejected write.
        for (int i = 0; i < 16; i++)
            exp_q.push_back({8'(8'h40 + i), 8'(8'h80 + i), 8'(8'hC0 + i)});
        for (int j = 0; j < 4; j++)
            drive(3'b001, 1, pack4(8'(8'h40 + 4 * j)));
        drive(3'b001, 0, 32'hEE);
        check("full R overflow", 32'(overflow), 32'd1);
        for (int j = 0; j < 4; j++)
            drive(3'b010, 1, pack4(8'(8'h80 + 4 * j)));
        for (int j = 0; j < 4; j++)
            drive(3'b100, 1, pack4(8'(8'hC0 + 4 * j)));
        wait_drain("full R");
        check("full R pix_count", pix_count, 32'd17);
        check("full R en_err", 32'(en_err), 32'd0);

        // Fifteen bytes in R: vector write rejected, scalar write accepted.
        do_reset();
        for (int i = 0; i < 16; i++)
            exp_q.push_back({8'(8'h10 + i), 8'(8'h20 + i), 8'(8'h30 + i)});
        for (int j = 0; j < 3; j++)
            drive(3'b001, 1, pack4(8'(8'h10 + 4 * j)));
        drive(3'b001, 0, 32'h1C);
        drive(3'b001, 0, 32'h1D);
        drive(3'b001, 0, 32'h1E);
        check("R at 15 no overflow", 32'(overflow), 32'd0);
        drive(3'b001, 1, 32'hDDDDDDDD);
        check("R at 15 vector overflow", 32'(overflow), 32'd1);
        drive(3'b001, 0, 32'h1F);
        for (int j = 0; j < 4; j++)
            drive(3'b010, 1, pack4(8'(8'h20 + 4 * j)));
        for (int j = 0; j < 4; j++)
            drive(3'b100, 1, pack4(8'(8'h30 + 4 * j)));
        wait_drain("R at 15");
        check("R at 15 pix_count", pix_count, 32'd16);

        // Misaligned start so vector pushes straddle the pointer wrap.
        do_reset();
        exp_q.push_back(24'h010203);
        drive(3'b001, 0, 32'h01);
        drive(3'b010, 0, 32'h02);
        drive(3'b100, 0, 32'h03);
        for (int i = 0; i < 40; i++) begin
            for (int k = 0; k < 4; k++) begin
                b = 8'(4 * i + k);
                rw[8*k +: 8] = b;
                gw[8*k +: 8] = b ^ 8'hA5;
                bw[8*k +: 8] = ~b;
                exp_q.push_back({b, b ^ 8'hA5, ~b});
            end
            drive(3'b001, 1, rw);
            drive(3'b010, 1, gw);
            drive(3'b100, 1, bw);
            step();
        end
        wait_drain("wrap stream");
        check("wrap pix_count", pix_count, 32'd161);
        check("wrap overflow", 32'(overflow), 32'd0);
        check("wrap en_err", 32'(en_err), 32'd0);

        mon_on = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
        $finish;
    end

endmodule
